// File: rtl/fp_addsub_pipe_if.sv
// Handshake bundle for fp_addsub_pipe: input operands with valid/ready,
// lane results with valid/ready and per-lane overflow flags.
interface fp_addsub_pipe_if #(
    parameter int W = 16,
    parameter int N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_a;
    logic [N*W-1:0] in_b;
    logic [N-1:0]   in_sub;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_res;
    logic [N-1:0]   out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_res, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_res, out_ovf
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Two-stage N-lane signed fixed-point add/subtract with overflow flags and a
// saturating overflow-event counter. Define FP_ADDSUB_SAT_EN to clamp overflowed lanes.
module fp_addsub_pipe #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_addsub_pipe_if.slave  bus,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    if (FRAC < 0 || FRAC >= W) begin : g_bad_frac
        $error("fp_addsub_pipe: FRAC must lie in [0, W-1]");
    end

    // Both operands widened by one bit so that negating -2^(W-1) cannot wrap.
    function automatic logic signed [W:0] add_lane(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b,
                                                   input logic                sub);
        logic signed [W:0] ae;
        logic signed [W:0] be;
        ae = {a[W-1], a};
        be = {b[W-1], b};
        if (sub)
            add_lane = ae + (~be + (W+1)'(1));
        else
            add_lane = ae + be;
    endfunction

    function automatic logic signed [W-1:0] sat_lane(input logic signed [W:0] r);
`ifdef FP_ADDSUB_SAT_EN
        if (r[W] != r[W-1])
            sat_lane = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            sat_lane = r[W-1:0];
`else
        sat_lane = r[W-1:0];
`endif
    endfunction

    logic           vld_p1;
    logic           vld_p2;
    logic           adv1;
    logic           adv2;
    logic [N*W-1:0] a_p1;
    logic [N*W-1:0] b_p1;
    logic [N-1:0]   sub_p1;
    logic [N*W-1:0] res_p2;
    logic [N-1:0]   ovf_p2;
    logic [N*W-1:0] res_c;
    logic [N-1:0]   ovf_c;
    logic signed [W:0] r_c;

    assign adv2         = ~vld_p2 | bus.out_ready;
    assign adv1         = ~vld_p1 | adv2;
    assign bus.in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv1) vld_p1 <= bus.in_valid;
            if (adv2) vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            a_p1   <= bus.in_a;
            b_p1   <= bus.in_b;
            sub_p1 <= bus.in_sub;
        end
    end

    always_comb begin
        res_c = '0;
        ovf_c = '0;
        r_c   = '0;
        for (int i = 0; i < N; i++) begin
            r_c                = add_lane(a_p1[i*W +: W], b_p1[i*W +: W], sub_p1[i]);
            ovf_c[i]           = r_c[W] ^ r_c[W-1];
            res_c[i*W +: W]    = sat_lane(r_c);
        end
    end

    // ---- stage 2: result register, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p2 <= '0;
            ovf_p2 <= '0;
        end else if (adv2 && vld_p1) begin
            res_p2 <= res_c;
            ovf_p2 <= ovf_c;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_res   = res_p2;
    assign bus.out_ovf   = ovf_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_count <= '0;
        else if (ovf_clr)
            ovf_count <= '0;
        else if (vld_p2 && bus.out_ready && (|ovf_p2) && !(&ovf_count))
            ovf_count <= ovf_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Randomised and directed bench for fp_addsub_pipe against an integer-arithmetic
// reference model; also exercises a CNT_W=2 instance for counter saturation.
module tb_fp_addsub_pipe;
    localparam int W     = 16;
    localparam int FRAC  = 8;
    localparam int N     = 4;
    localparam int CNT_W = 16;
    localparam int NW    = N * W;
    localparam int MAXV  = 2 ** (W - 1) - 1;
    localparam int MINV  = -(2 ** (W - 1));

`ifdef FP_ADDSUB_SAT_EN
    localparam logic [15:0] E_POS  = 16'h7FFF;
    localparam logic [15:0] E_NEG  = 16'h8000;
    localparam logic [15:0] E_NEGB = 16'h7FFF;
`else
    localparam logic [15:0] E_POS  = 16'h8100;
    localparam logic [15:0] E_NEG  = 16'h7F00;
    localparam logic [15:0] E_NEGB = 16'h8000;
`endif

    typedef struct packed {
        logic [NW-1:0] res;
        logic [N-1:0]  ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ovf_clr;
    logic [CNT_W-1:0] ovf_count;
    logic [1:0] ovf_count2;

    always #5 clk = ~clk;

    fp_addsub_pipe_if #(.W(W), .N(N)) bus ();
    fp_addsub_pipe_if #(.W(W), .N(N)) bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_a      = bus.in_a;
    assign bus2.in_b      = bus.in_b;
    assign bus2.in_sub    = bus.in_sub;
    assign bus2.out_ready = bus.out_ready;

    fp_addsub_pipe #(.W(W), .FRAC(FRAC), .N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
    );

    fp_addsub_pipe #(.W(W), .FRAC(FRAC), .N(N), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .ovf_clr(ovf_clr), .ovf_count(ovf_count2)
    );

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [CNT_W-1:0] mdl_cnt = '0;
    logic [1:0]       mdl_cnt2 = '0;
    logic             prev_stall = 1'b0;
    logic [NW-1:0]    prev_res = '0;
    logic [N-1:0]     prev_ovf = '0;
    logic             obs_hs, obs_in_hs;
    logic [NW-1:0]    obs_res;
    logic [N-1:0]     obs_ovf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer sum/difference, then range test and clamp or wrap.
    function automatic exp_t model(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                   input logic [N-1:0] sub);
        exp_t e;
        int av, bv, r;
        logic [31:0] ru;
        e = '0;
        for (int i = 0; i < N; i++) begin
            av = $signed(a[i*W +: W]);
            bv = $signed(b[i*W +: W]);
            r  = sub[i] ? av - bv : av + bv;
            e.ovf[i] = (r > MAXV) || (r < MINV);
`ifdef FP_ADDSUB_SAT_EN
            if (r > MAXV) r = MAXV;
            else if (r < MINV) r = MINV;
`endif
            ru = r;
            e.res[i*W +: W] = ru[W-1:0];
        end
        return e;
    endfunction

    // One clock cycle: drive at the falling edge, check 1 time unit later.
    task automatic step(input logic iv, input logic [NW-1:0] a, input logic [NW-1:0] b,
                        input logic [N-1:0] sub, input logic ordy, input logic clr);
        exp_t e;
        logic hs_ovf;
        bus.in_valid  = iv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        bus.out_ready = ordy;
        ovf_clr       = clr;
        #1;
        chk("ovf_count", 64'(ovf_count), 64'(mdl_cnt));
        chk("ovf_count_c2", 64'(ovf_count2), 64'(mdl_cnt2));
        if (prev_stall) begin
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_res", bus.out_res, prev_res);
            chk("stall_ovf", 64'(bus.out_ovf), 64'(prev_ovf));
        end
        obs_hs  = bus.out_valid && ordy;
        obs_res = bus.out_res;
        obs_ovf = bus.out_ovf;
        hs_ovf  = 1'b0;
        if (obs_hs) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h, expected no output", bus.out_res);
            end else begin
                e = q.pop_front();
                chk("out_res", bus.out_res, e.res);
                chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
                hs_ovf = |e.ovf;
            end
        end
        prev_stall = bus.out_valid && !ordy;
        prev_res   = bus.out_res;
        prev_ovf   = bus.out_ovf;
        obs_in_hs  = iv && bus.in_ready;
        if (obs_in_hs) q.push_back(model(a, b, sub));
        if (clr) begin
            mdl_cnt  = '0;
            mdl_cnt2 = '0;
        end else if (hs_ovf) begin
            if (mdl_cnt != '1) mdl_cnt++;
            if (mdl_cnt2 != 2'b11) mdl_cnt2++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, '0, ordy, 1'b0);
    endtask

    task automatic directed(input string nm, input logic [NW-1:0] a, input logic [NW-1:0] b,
                            input logic [N-1:0] sub, input logic [NW-1:0] er,
                            input logic [N-1:0] eo);
        int lat;
        step(1'b1, a, b, sub, 1'b1, 1'b0);
        chk({nm, "_accept"}, 64'(obs_in_hs), 64'd1);
        lat = 9;
        for (int k = 1; k <= 8; k++) begin
            idle(1'b1);
            if (obs_hs) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, 64'(lat), 64'd2);
        chk({nm, "_res"}, obs_res, er);
        chk({nm, "_ovf"}, 64'(obs_ovf), 64'(eo));
    endtask

    function automatic logic [15:0] rnd_word();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'h7F00;
            default: return v[15:0];
        endcase
    endfunction

    function automatic logic [NW-1:0] rnd_vec();
        logic [NW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = rnd_word();
        return v;
    endfunction

    initial begin
        logic [NW-1:0] bp_a[6];
        logic [NW-1:0] bp_b[6];
        logic [N-1:0]  bp_s[6];
        int idx, rx;
        logic saw_block;
        logic [3:0] rs;

        bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = '0;
        bus.out_ready = 0; ovf_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_res", bus.out_res, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        chk("rst_ovf_count", 64'(ovf_count), 64'd0);
        @(negedge clk);

        directed("add_5_5",    64'h0500, 64'h0500, 4'b0000, 64'h0A00, 4'b0000);
        directed("sub_5_5",    64'h0500, 64'h0500, 4'b0001, 64'h0000, 4'b0000);
        directed("ovf_pos",    64'h7F00, 64'h0200, 4'b0000, 64'(E_POS), 4'b0001);
        directed("ovf_neg",    64'h8000, 64'h0100, 4'b0001, 64'(E_NEG), 4'b0001);
        directed("neg_minint", 64'h0000, 64'h8000, 4'b0001, 64'(E_NEGB), 4'b0001);
        directed("mixed", {4{16'h0100}}, {4{16'h0080}}, 4'b1010,
                 64'h0080_0180_0080_0180, 4'b0000);

        // Backpressure: six transactions, consumer stalls on cycles 3..5.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = rnd_vec();
            bp_b[i] = rnd_vec();
            rs = 4'($urandom);
            bp_s[i] = rs;
        end
        idx = 0; rx = 0; saw_block = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx < 6)
                step(1'b1, bp_a[idx], bp_b[idx], bp_s[idx], !(cyc >= 3 && cyc <= 5), 1'b0);
            else
                idle(1'b1);
            if (idx < 6 && !obs_in_hs) saw_block = 1'b1;
            if (obs_in_hs) idx++;
            if (obs_hs) rx++;
            if (idx == 6 && q.size() == 0) break;
        end
        chk("bp_accepted", 64'(idx), 64'd6);
        chk("bp_received", 64'(rx), 64'd6);
        chk("bp_in_ready_low", 64'(saw_block), 64'd1);

        // Randomised traffic with random stalls and occasional counter clears.
        for (int cyc = 0; cyc < 400; cyc++) begin
            rs = 4'($urandom);
            step($urandom_range(0, 9) < 7, rnd_vec(), rnd_vec(), rs,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
        end
        for (int k = 0; k < 30 && q.size() > 0; k++) idle(1'b1);
        chk("random_drain", 64'(q.size()), 64'd0);

        // Overflow counter: count, clear-priority, saturation of the 2-bit instance.
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            directed("cnt_ovf", 64'h7F00, 64'h0200, 4'b0000, 64'(E_POS), 4'b0001);
        idle(1'b1);
        chk("cnt_three", 64'(ovf_count), 64'd3);
        step(1'b1, 64'h7F00, 64'h0200, 4'b0000, 1'b1, 1'b0);
        idle(1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1);
        chk("cnt_clr_hs", 64'(obs_hs), 64'd1);
        idle(1'b1);
        chk("cnt_clr_priority", 64'(ovf_count), 64'd0);
        for (int i = 0; i < 5; i++)
            directed("cnt_sat", 64'h8000, 64'h0100, 4'b0001, 64'(E_NEG), 4'b0001);
        idle(1'b1);
        chk("cnt_five", 64'(ovf_count), 64'd5);
        chk("cnt2_saturated", 64'(ovf_count2), 64'd3);

        // Reset with both stages occupied.
        step(1'b1, rnd_vec(), rnd_vec(), 4'b0000, 1'b0, 1'b0);
        step(1'b1, rnd_vec(), rnd_vec(), 4'b1111, 1'b0, 1'b0);
        #1;
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("pre_rst_full", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
        q.delete();
        mdl_cnt = '0;
        mdl_cnt2 = '0;
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 5; k++) idle(1'b1);
        directed("post_rst", 64'h0100, 64'h0100, 4'b0000, 64'h0200, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish within budget");
        $fatal(1, "timeout");
    end
endmodule
